// File: rtl/trap_sched_pkg.sv
// Shared types and default widths for the optical-trap pulse scheduler.
package trap_sched_pkg;

  localparam int unsigned STATE_W            = 3;
  localparam int unsigned DefaultPeriodWidth = 32;
  localparam int unsigned DefaultCountWidth  = 16;

  typedef enum logic [STATE_W-1:0] {
    StIdle,
    StArm,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/trap_pulse_scheduler_if.sv
// Control/status bundle between the register interface (master) and the scheduler (slave).
interface trap_pulse_scheduler_if #(
   parameter int unsigned PERIOD_WIDTH = trap_sched_pkg::DefaultPeriodWidth,
   parameter int unsigned COUNT_WIDTH  = trap_sched_pkg::DefaultCountWidth
) ();

   logic                    start_i;
   logic                    stop_i;
   logic [PERIOD_WIDTH-1:0] period_cycles_i;
   logic [PERIOD_WIDTH-1:0] settle_cycles_i;
   logic [COUNT_WIDTH-1:0]  pulse_count_i;
   logic                    trig_o;
   logic                    feedback_enable_o;
   logic                    busy_o;
   logic                    done_o;
   logic [COUNT_WIDTH-1:0]  trig_count_o;

   modport master (
      output start_i, stop_i, period_cycles_i, settle_cycles_i, pulse_count_i,
      input  trig_o, feedback_enable_o, busy_o, done_o, trig_count_o
   );

   modport slave (
      input  start_i, stop_i, period_cycles_i, settle_cycles_i, pulse_count_i,
      output trig_o, feedback_enable_o, busy_o, done_o, trig_count_o
   );

endinterface

// File: rtl/trap_period_timer.sv
// Loadable down-counter shared by the ARM, RUN and DRAIN phases; stops at zero (no wrap).
module trap_period_timer import trap_sched_pkg::*; #(
   parameter int unsigned PERIOD_WIDTH = DefaultPeriodWidth
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    load_i,
   input  logic                    en_i,
   input  logic [PERIOD_WIDTH-1:0] load_val_i,
   output logic                    expire_o
);

   logic [PERIOD_WIDTH-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - PERIOD_WIDTH'(1);
      end
   end

   assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/trap_pulse_scheduler.sv
// Trap feedback sequencer: enable, settle, periodic trigger burst, drain, done.
// Build option EXT_SYNC_EN: RUN triggers follow rising edges of ext_trig_i instead of the timer.
module trap_pulse_scheduler import trap_sched_pkg::*; #(
   parameter int unsigned PERIOD_WIDTH = DefaultPeriodWidth,
   parameter int unsigned COUNT_WIDTH  = DefaultCountWidth
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
`ifdef EXT_SYNC_EN
   input  logic                  ext_trig_i,
`endif
   trap_pulse_scheduler_if.slave bus
);

   state_e                  state_q;
   logic                    trig_q, enable_q, busy_q, done_q;
   logic [COUNT_WIDTH-1:0]  count_q, n_q, count_inc;
   logic [PERIOD_WIDTH-1:0] pm1_q, pm1_in, load_val;
   logic                    tmr_load, tmr_en, tmr_expire, trig_due, burst_done, start_ok;

   // A period of 0 behaves as 1, so its reload value is also 0.
   assign pm1_in     = (bus.period_cycles_i == '0) ? '0
                                                   : bus.period_cycles_i - PERIOD_WIDTH'(1);
   assign start_ok   = bus.start_i && !bus.stop_i;
   assign burst_done = (n_q != '0) && (count_q == n_q);
   assign count_inc  = (&count_q) ? count_q : count_q + COUNT_WIDTH'(1);
   assign tmr_en     = (state_q == StArm) || (state_q == StRun) || (state_q == StDrain);

`ifdef EXT_SYNC_EN
   localparam bit AutoFirst = 1'b0;
   logic [2:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], ext_trig_i};
      end
   end

   assign trig_due = sync_q[1] & ~sync_q[2];
`else
   localparam bit AutoFirst = 1'b1;
   assign trig_due = tmr_expire;
`endif

   always_comb begin
      tmr_load = 1'b0;
      load_val = pm1_q;
      unique case (state_q)
         StIdle: begin
            tmr_load = start_ok;
            load_val = (bus.settle_cycles_i == '0) ? pm1_in
                                                   : bus.settle_cycles_i - PERIOD_WIDTH'(1);
         end
         StArm:   tmr_load = tmr_expire && !bus.stop_i;
         StRun:   tmr_load = bus.stop_i || burst_done || tmr_expire;
         default: ;
      endcase
   end

   trap_period_timer #(
      .PERIOD_WIDTH(PERIOD_WIDTH)
   ) u_timer (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (tmr_load),
      .en_i       (tmr_en),
      .load_val_i (load_val),
      .expire_o   (tmr_expire)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         trig_q   <= 1'b0;
         enable_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         count_q  <= '0;
         n_q      <= '0;
         pm1_q    <= '0;
      end else begin
         trig_q <= 1'b0;
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_ok) begin
                  pm1_q    <= pm1_in;
                  n_q      <= bus.pulse_count_i;
                  enable_q <= 1'b1;
                  busy_q   <= 1'b1;
                  if (bus.settle_cycles_i == '0) begin
                     state_q <= StRun;
                     trig_q  <= AutoFirst;
                     count_q <= COUNT_WIDTH'(AutoFirst);
                  end else begin
                     state_q <= StArm;
                     count_q <= '0;
                  end
               end
            end
            StArm: begin
               if (bus.stop_i) begin
                  state_q  <= StDone;
                  enable_q <= 1'b0;
                  done_q   <= 1'b1;
               end else if (tmr_expire) begin
                  state_q <= StRun;
                  trig_q  <= AutoFirst;
                  count_q <= COUNT_WIDTH'(AutoFirst);
               end
            end
            StRun: begin
               // Stop and burst completion both take priority over a due trigger.
               if (bus.stop_i || burst_done) begin
                  state_q <= StDrain;
               end else if (trig_due) begin
                  trig_q  <= 1'b1;
                  count_q <= count_inc;
               end
            end
            StDrain: begin
               if (tmr_expire) begin
                  state_q  <= StDone;
                  enable_q <= 1'b0;
                  done_q   <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.trig_o            = trig_q;
   assign bus.feedback_enable_o = enable_q;
   assign bus.busy_o            = busy_q;
   assign bus.done_o            = done_q;
   assign bus.trig_count_o      = count_q;

endmodule

// File: tb/tb_trap_pulse_scheduler.sv
// Randomised bench for trap_pulse_scheduler against a burst-timeline model.
module tb_trap_pulse_scheduler;

   localparam int unsigned PW = 32;
   localparam int unsigned CW = 16;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;

   trap_pulse_scheduler_if #(.PERIOD_WIDTH(PW), .COUNT_WIDTH(CW)) bus ();

`ifdef EXT_SYNC_EN
   logic ext_trig = 1'b0;
`endif

   trap_pulse_scheduler #(
      .PERIOD_WIDTH(PW),
      .COUNT_WIDTH (CW)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
`ifdef EXT_SYNC_EN
      .ext_trig_i (ext_trig),
`endif
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;
   logic exp_trig, exp_en, exp_busy, exp_done;
   longint exp_cnt;
   longint prev_cnt = 0;

   // Burst timeline, relative to the cycle in which start is presented (cycle 0).
   int m_pe, m_r0, m_d, m_done;
   bit m_arm_stop;
   int obs_trig[$];
   int obs_done;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("trig_o", longint'(bus.trig_o), longint'(exp_trig));
         check("feedback_enable_o", longint'(bus.feedback_enable_o), longint'(exp_en));
         check("busy_o", longint'(bus.busy_o), longint'(exp_busy));
         check("done_o", longint'(bus.done_o), longint'(exp_done));
         check("trig_count_o", longint'(bus.trig_count_o), exp_cnt);
      end
   end

   function automatic void plan(input int s, input int p, input int n, input int stopk);
      int t_end;
      m_pe = (p == 0) ? 1 : p;
      m_r0 = s + 1;
      m_arm_stop = (stopk >= 1) && (stopk <= s);
      if (m_arm_stop) begin
         m_d = 0;
         m_done = stopk + 1;
      end else begin
         t_end = (n > 0) ? m_r0 + (n - 1) * m_pe : 32'h3fff_ffff;
         m_d = (stopk >= m_r0 && stopk <= t_end) ? stopk + 1 : t_end + 1;
         m_done = m_d + m_pe;
      end
   endfunction

   // Triggers issued in cycles 1..c: every P cycles from RUN entry up to the last RUN cycle.
   function automatic longint trigs_upto(input int c);
      int last;
      if (m_arm_stop || c < m_r0) return 0;
      last = (c < m_d - 1) ? c : m_d - 1;
      if (last < m_r0) return 0;
      return longint'((last - m_r0) / m_pe + 1);
   endfunction

   function automatic longint sat(input longint x);
      return (x > 65535) ? 65535 : x;
   endfunction

   task automatic set_idle_exp();
      exp_trig = 1'b0;
      exp_en   = 1'b0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_cnt  = prev_cnt;
   endtask

   task automatic idle_cycle(input logic start, input logic stop);
      @(posedge clk); #1;
      set_idle_exp();
      bus.start_i = start;
      bus.stop_i  = stop;
      chk_en = 1'b1;
   endtask

   task automatic run_burst(input int s, input int p, input int n, input int stopk,
                            input int abort_c);
      plan(s, p, n, stopk);
      obs_trig.delete();
      obs_done = -1;
      for (int c = 0; c <= m_done; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            set_idle_exp();
            bus.start_i = 1'b1;
            bus.stop_i = 1'b0;
            bus.settle_cycles_i = PW'(s);
            bus.period_cycles_i = PW'(p);
            bus.pulse_count_i = CW'(n);
         end else begin
            exp_trig = trigs_upto(c) != trigs_upto(c - 1);
            exp_en   = c < m_done;
            exp_busy = 1'b1;
            exp_done = c == m_done;
            exp_cnt  = sat(trigs_upto(c));
            bus.start_i = 1'($urandom);
            bus.stop_i = (c == stopk);
            bus.settle_cycles_i = $urandom;
            bus.period_cycles_i = $urandom;
            bus.pulse_count_i = CW'($urandom);
            if (bus.trig_o) obs_trig.push_back(c);
            if (bus.done_o) obs_done = c;
         end
         chk_en = 1'b1;
         if (c == abort_c) begin
            chk_en = 1'b0;
            #2 rst_ni = 1'b0;
            #1;
            check("abort_trig", longint'(bus.trig_o), 0);
            check("abort_enable", longint'(bus.feedback_enable_o), 0);
            check("abort_busy", longint'(bus.busy_o), 0);
            check("abort_count", longint'(bus.trig_count_o), 0);
            prev_cnt = 0;
            return;
         end
      end
      prev_cnt = sat(trigs_upto(m_done));
   endtask

   initial begin
      int s, p, n, stopk, span;
      bus.start_i = 1'b0;
      bus.stop_i = 1'b0;
      bus.period_cycles_i = '0;
      bus.settle_cycles_i = '0;
      bus.pulse_count_i = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_trig", longint'(bus.trig_o), 0);
      check("reset_enable", longint'(bus.feedback_enable_o), 0);
      check("reset_busy", longint'(bus.busy_o), 0);
      check("reset_done", longint'(bus.done_o), 0);
      check("reset_count", longint'(bus.trig_count_o), 0);
      rst_ni = 1'b1;

`ifdef EXT_SYNC_EN
      begin
         int edges[3] = '{8, 14, 20};
         obs_trig.delete();
         obs_done = -1;
         @(posedge clk); #1;
         bus.start_i = 1'b1;
         bus.settle_cycles_i = 32'd5;
         bus.period_cycles_i = 32'd3;
         bus.pulse_count_i = 16'd3;
         for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            ext_trig = (c == 1) || (c == edges[0]) || (c == edges[1]) || (c == edges[2]);
            if (bus.trig_o) obs_trig.push_back(c);
            if (bus.done_o) obs_done = c;
         end
         check("ext_trig_total", longint'(obs_trig.size()), 3);
         for (int i = 0; i < 3 && i < obs_trig.size(); i++)
            check("ext_trig_latency", longint'(obs_trig[i]), longint'(edges[i] + 3));
         check("ext_done_cycle", longint'(obs_done), longint'(edges[2] + 3 + 1 + 3));
         check("ext_count", longint'(bus.trig_count_o), 3);
      end
`else
      // Enable from cycle 1, triggers at 4/8/12, drain 13..16, done at 17.
      run_burst(3, 4, 3, -1, -1);
      check("t1_trig_total", longint'(obs_trig.size()), 3);
      if (obs_trig.size() == 3) begin
         check("t1_trig0", longint'(obs_trig[0]), 4);
         check("t1_trig1", longint'(obs_trig[1]), 8);
         check("t1_trig2", longint'(obs_trig[2]), 12);
      end
      check("t1_done_cycle", longint'(obs_done), 17);
      idle_cycle(1'b0, 1'b0);
      check("t1_final_count", longint'(bus.trig_count_o), 3);

      run_burst(0, 1, 5, -1, -1);
      check("t2_trig_total", longint'(obs_trig.size()), 5);
      if (obs_trig.size() == 5) begin
         check("t2_first", longint'(obs_trig[0]), 1);
         check("t2_last", longint'(obs_trig[4]), 5);
      end
      check("t2_done_cycle", longint'(obs_done), 7);

      // Stop lands in cycle 20, the cycle before the trigger due at 21.
      run_burst(0, 10, 0, 20, -1);
      check("t3_trig_total", longint'(obs_trig.size()), 2);
      if (obs_trig.size() == 2) check("t3_second", longint'(obs_trig[1]), 11);
      check("t3_done_cycle", longint'(obs_done), 31);

      run_burst(20, 3, 4, 5, -1);
      check("t4_trig_total", longint'(obs_trig.size()), 0);
      check("t4_done_cycle", longint'(obs_done), 6);

      idle_cycle(1'b1, 1'b1);
      idle_cycle(1'b0, 1'b0);
      idle_cycle(1'b0, 1'b0);

      run_burst(2, 3, 0, 40, 8);
      @(posedge clk); #1;
      rst_ni = 1'b1;
      set_idle_exp();
      bus.start_i = 1'b0;
      bus.stop_i = 1'b0;
      chk_en = 1'b1;
      repeat (3) idle_cycle(1'b0, 1'b0);

      for (int k = 0; k < 60; k++) begin
         s = $urandom_range(0, 5);
         p = $urandom_range(0, 6);
         n = $urandom_range(0, 6);
         span = s + ((p == 0) ? 1 : p) * ((n == 0) ? 5 : n) + 3;
         stopk = (n == 0 || $urandom_range(0, 2) == 0) ? $urandom_range(1, span) : -1;
         run_burst(s, p, n, stopk, -1);
         if ($urandom_range(0, 3) == 0) idle_cycle(1'b0, 1'($urandom));
      end
      idle_cycle(1'b0, 1'b0);
`endif

      @(posedge clk); #1;
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
